uart_echo_responder: RTL

//  Host-side responder for the UART pair: accepts bytes from the receiver (dout/rx_done),

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_sync_fifo.sv | 76 +++++++
 rtl/uart_echo_responder.sv | 102 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: echo FSM state encoding, ASCII case constants and
// a lower-to-upper case helper used by the optional upcase path
// (UART_ECHO_UPCASE_EN in uart_echo_responder).
package uart_pkg;

  // Echo responder FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } echo_state_e;

  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  // Map 'a'..'z' to 'A'..'Z'; every other value passes through untouched.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if ((b >= ASCII_LC_A) && (b <= ASCII_LC_Z)) begin
      r = b - ASCII_CASE_OFS;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset. The head entry is
// read combinationally so the consumer can capture it on the same edge that
// pops it. A push into a full FIFO is accepted only if a pop happens on the
// same edge.
module uart_sync_fifo #(
  parameter int W      = 8,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [W-1:0]    din_i,
  output logic [W-1:0]    dout_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [ADDR_W:0] count_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [W-1:0]      mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Qualify requests: pops need data, pushes need room or a concurrent pop
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Next pointer / occupancy values; pointers wrap naturally modulo DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage write; contents need no reset because occupancy gates reads
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_echo_responder.sv
// Echo responder: buffers bytes from the UART receiver and replays them one
// at a time to the transmitter, waiting for tx_done between bytes.
// Optional feature: define UART_ECHO_UPCASE_EN to convert 'a'..'z' to upper
// case as each byte is popped into tx_data (FIFO keeps raw bytes).
module uart_echo_responder
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rx_dout,
  input  logic            rx_done,
  output logic [7:0]      tx_data,
  output logic            tx_transmission,
  input  logic            tx_done,
  output logic [ADDR_W:0] fifo_count,
  output logic            overflow
);

  echo_state_e state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_trans_q, tx_trans_d;
  logic        overflow_q, overflow_d;

  logic [7:0]  fifo_head;
  logic [7:0]  load_byte;
  logic        fifo_full, fifo_empty;
  logic        fifo_pop;

  // The FSM pops exactly when it is idle and something is buffered
  assign fifo_pop = (state_q == IDLE) & ~fifo_empty;

  uart_sync_fifo #(
    .W      (8),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_done),
    .pop_i   (fifo_pop),
    .din_i   (rx_dout),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef UART_ECHO_UPCASE_EN
  assign load_byte = to_upper(fifo_head);
`else
  assign load_byte = fifo_head;
`endif

  // Sticky drop flag: a byte arrived with no room and no pop to make room
  assign overflow_d = overflow_q | (rx_done & fifo_full & ~fifo_pop);

  // Next-state and registered-output logic for the replay FSM
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_trans_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          tx_data_d = load_byte;
          state_d   = START;
        end
      end
      START: begin
        tx_trans_d = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any request in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_trans_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_trans_q <= tx_trans_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_data         = tx_data_q;
  assign tx_transmission = tx_trans_q;
  assign overflow        = overflow_q;

endmodule
